bit_to_byte_packer: RTL and testbench
=====================================

// Module: bit_to_byte_packer
// PURPOSE
//  Encoder-side packer: accepts the serial Huffman code bitstream one bit per handshake and
//  packs it LSB-first into bytes. Each completed byte is written to the output byte FIFO.
//  On flush, it zero-pads and writes the final partial byte, then signals completion.
//  Sits between the Huffman code emitter and the output FIFO; mirror of the decode-side byte-to-bit serializer.
// PARAMETERS
//  DATA_W   8   bits per output word (FIFO width)
//  CNT_W    16  width of the bytes_written counter
// PORTS
//  clk            in   1        rising-edge clock
//  n_rst          in   1        reset, synchronous, active-low
//  bit_valid      in   1        bit_in is valid this cycle
//  bit_in         in   1        next code bit, first-emitted bit first
//  bit_ready      out  1        packer accepts bit_in this cycle (combinational)
//  flush          in   1        end-of-stream pulse from encoder control
//  full           in   1        output FIFO full
//  w_en           out  1        FIFO write strobe, registered, one cycle per word
//  wdata          out  DATA_W   FIFO write data, registered, valid while w_en=1
//  flush_done     out  1        one-cycle pulse after the last write of a flush
//  bytes_written  out  CNT_W    words written since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: w_en=0, wdata=0, flush_done=0, bytes_written=0, cnt=0, sr=0, no pending word, state=COLLECT.
//  A bit is accepted when bit_valid && bit_ready. The accepted bit goes to sr[cnt], then cnt++.
//  bit_ready = (state==COLLECT) && !pending.
//  When cnt reaches DATA_W:
//    - sr moves to the pending holding register.
//    - cnt=0 and sr=0 on the same edge.
//  Write rule: at any edge where pending && !full:
//    - w_en<=1, wdata<=pending word, pending cleared, bytes_written++.
//    - w_en is low on the next edge unless another word is pending.
//  Latency: 8th bit accepted at edge k; with full=0 at k+1, w_en is high in the cycle after k+1.
//  Backpressure: while full=1, the word stays pending, bit_ready=0, w_en=0. No bits are lost.
//  States: COLLECT -> FLUSH_WR -> [TRAILER] -> DONE -> COLLECT.
//    - COLLECT: accepts bits. A flush seen while pending is held until pending clears.
//    - A bit and flush in the same cycle: the bit is accepted first and included in the final word.
//    - FLUSH_WR:
//        - cnt>0: the upper DATA_W-cnt bits are zero; write sr under the write rule.
//        - cnt==0: no write.
//        - Latch last_bits = cnt if cnt>0; else DATA_W if bytes_written>0; else 0.
//    - DONE: flush_done=1 for one cycle; cnt=0; back to COLLECT.
//  flush while not in COLLECT is ignored. bit_valid while bit_ready=0 is not consumed.
//  Reset mid-operation: partial and pending data are discarded; no w_en is issued.
// CONFIGURATION
//  Macro BIT_PACK_TRAILER_EN.
//  Defined:
//    - FLUSH_WR goes to TRAILER.
//    - TRAILER writes one extra word = last_bits (zero-extended) under the write rule.
//    - bytes_written includes the trailer word.
//    - flush_done follows the trailer write.
//  Undefined: no TRAILER state; FLUSH_WR goes straight to DONE.
// STRUCTURE
//  Shared package huff_pkg:
//    - pack_state_t enum {COLLECT, FLUSH_WR, TRAILER, DONE}
//    - HUFF_DATA_W=8 constant, the default for DATA_W
//  No sub-module: one always_ff for state, sr, cnt, pending and outputs; one always_comb for next state and bit_ready.
// TESTING
//  1. Bits 1,0,1,1,0,0,1,0, full=0:
//     -> one w_en pulse, wdata=8'h4D, bytes_written=1, bit_ready high throughout.
//  2. Bits 1,1,0 then flush:
//     -> wdata=8'h03, flush_done pulse.
//     -> with TRAILER_EN: second write 8'h03, bytes_written=2.
//  3. 8 bits 8'hFF with full=1 for 5 cycles after the 8th bit:
//     -> bit_ready=0 and w_en=0 during stall.
//     -> one write of 8'hFF after full drops, 9th bit then accepted.
//  4. 16 bits then flush with cnt=0:
//     -> no data write in FLUSH_WR.
//     -> TRAILER_EN: trailer 8'h08. Without it: flush_done only.
//  5. Flush right after reset, no bits: no data write. With TRAILER_EN: one write 8'h00.
//  6. 5 bits, then n_rst=0 one cycle, then 8 bits of 1:
//     -> exactly one write 8'hFF, bytes_written=1.

Source files
------------

// File: rtl/huff_pkg.sv
// huff_pkg: shared Huffman-path types and constants.
package huff_pkg;
    typedef enum logic [1:0] {COLLECT, FLUSH_WR, TRAILER, DONE} pack_state_t;
    localparam int HUFF_DATA_W = 8;
endpackage

// File: rtl/bit_to_byte_packer.sv
// bit_to_byte_packer: packs a serial code bitstream LSB-first into FIFO words, zero-pads on flush.
// BIT_PACK_TRAILER_EN appends a trailer word holding the valid bit count of the last word.
module bit_to_byte_packer
    import huff_pkg::*;
#(
    parameter int DATA_W = HUFF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    input  logic              flush,
    input  logic              full,
    output logic              w_en,
    output logic [DATA_W-1:0] wdata,
    output logic              flush_done,
    output logic [CNT_W-1:0]  bytes_written
);
    localparam int CW = $clog2(DATA_W + 1);
`ifdef BIT_PACK_TRAILER_EN
    localparam pack_state_t AFTER_FLUSH = TRAILER;
`else
    localparam pack_state_t AFTER_FLUSH = DONE;
`endif

    pack_state_t       state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d, pword_q;
    logic [CW-1:0]     cnt_q, last_bits_d;
    logic              pend_q, acc, wr;
`ifdef BIT_PACK_TRAILER_EN
    logic [CW-1:0]     last_bits_q;
`endif

    always_comb begin
        state_d     = state_q;
        bit_ready   = (state_q == COLLECT) && !pend_q;
        acc         = bit_valid && bit_ready;
        wr          = pend_q && !full;
        sr_d        = sr_q | (DATA_W'(bit_in) << cnt_q);
        last_bits_d = (cnt_q != '0) ? cnt_q : ((bytes_written != '0) ? CW'(DATA_W) : '0);
        // every post-flush state waits for the pending word to drain first
        case (state_q)
            COLLECT:  state_d = flush ? FLUSH_WR : COLLECT;
            FLUSH_WR: state_d = pend_q ? FLUSH_WR : AFTER_FLUSH;
            TRAILER:  state_d = pend_q ? TRAILER : DONE;
            DONE:     state_d = pend_q ? DONE : COLLECT;
            default:  state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= COLLECT;
            sr_q          <= '0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            pword_q       <= '0;
            w_en          <= 1'b0;
            wdata         <= '0;
            flush_done    <= 1'b0;
            bytes_written <= '0;
`ifdef BIT_PACK_TRAILER_EN
            last_bits_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            w_en       <= wr;
            flush_done <= 1'b0;
            if (wr) begin
                wdata         <= pword_q;
                pend_q        <= 1'b0;
                bytes_written <= bytes_written + 1'b1;
            end
            if (acc && cnt_q == CW'(DATA_W - 1)) begin
                pend_q  <= 1'b1;
                pword_q <= sr_d;
                sr_q    <= '0;
                cnt_q   <= '0;
            end else if (acc) begin
                sr_q  <= sr_d;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FLUSH_WR && !pend_q) begin
                pend_q  <= cnt_q != '0;
                pword_q <= sr_q;
                sr_q    <= '0;
                cnt_q   <= '0;
`ifdef BIT_PACK_TRAILER_EN
                last_bits_q <= last_bits_d;
`endif
            end
`ifdef BIT_PACK_TRAILER_EN
            if (state_q == TRAILER && !pend_q) begin
                pend_q  <= 1'b1;
                pword_q <= DATA_W'(last_bits_q);
            end
`endif
            if (state_q == DONE && !pend_q) begin
                flush_done <= 1'b1;
                cnt_q      <= '0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^last_bits_d;
endmodule

// File: tb/tb_bit_to_byte_packer.sv
// tb_bit_to_byte_packer: table-driven and scoreboard checks of the LSB-first bit packer.
module tb_bit_to_byte_packer;
    logic        clk = 1'b0;
    logic        n_rst, bit_valid, bit_in, flush, full;
    logic        bit_ready, w_en, flush_done;
    logic [7:0]  wdata;
    logic [15:0] bytes_written;

    int          vecs = 0, errs = 0, bw_exp = 0;
    logic [7:0]  q[$];

    typedef struct {
        int          n;
        logic [15:0] pat;
        logic        fl;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    bit_to_byte_packer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .flush(flush), .full(full), .w_en(w_en),
        .wdata(wdata), .flush_done(flush_done), .bytes_written(bytes_written)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (w_en) begin
            vecs++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write: got %0h, expected no write at %0t", wdata, $time);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (wdata !== e) begin
                    errs++;
                    $display("FAIL wdata: got %0h, expected %0h at %0t", wdata, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        bw_exp++;
    endtask

    task automatic send_bit(input logic b, input logic must);
        int t = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        if (must) chk("bit_ready", {31'b0, bit_ready}, 1);
        while (!bit_ready && t < 60) begin
            tick();
            t++;
        end
        if (!bit_ready) chk("ready_timeout", {31'b0, bit_ready}, 1);
        tick();
        bit_valid = 1'b0;
    endtask

    // partial word (if any) and optional trailer expected from a flush with r leftover bits
    task automatic exp_flush(input int r, input logic [7:0] part);
        if (r != 0) push(part);
`ifdef BIT_PACK_TRAILER_EN
        push((r != 0) ? 8'(r) : ((bw_exp > 0) ? 8'd8 : 8'd0));
`endif
    endtask

    task automatic wait_done();
        int t = 0;
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        bit_valid = 1'b0;
        while (!flush_done && t < 80) begin
            tick();
            t++;
        end
        chk("flush_done", {31'b0, flush_done}, 1);
        chk("drained_at_done", q.size(), 0);
        tick();
        chk("flush_done_pulse", {31'b0, flush_done}, 0);
        chk("bytes_written", {16'b0, bytes_written}, bw_exp);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        tick();
        chk("drain", q.size(), 0);
        chk("bytes_written", {16'b0, bytes_written}, bw_exp);
    endtask

    initial begin
        logic [7:0]  b8;
        logic [15:0] p;
        tbl[0] = '{8,  16'h00A5, 1'b0};
        tbl[1] = '{3,  16'h0003, 1'b1};
        tbl[2] = '{5,  16'h0016, 1'b1};
        tbl[3] = '{16, 16'hC35A, 1'b1};
        tbl[4] = '{0,  16'h0000, 1'b1};
        tbl[5] = '{12, 16'h0ABC, 1'b1};
        n_rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; full = 1'b0;
        repeat (3) tick();
        chk("rst_w_en", {31'b0, w_en}, 0);
        chk("rst_wdata", {24'b0, wdata}, 0);
        chk("rst_flush_done", {31'b0, flush_done}, 0);
        chk("rst_bytes_written", {16'b0, bytes_written}, 0);
        n_rst = 1'b1;
        tick();
        chk("rst_bit_ready", {31'b0, bit_ready}, 1);

        // flush with no bits since reset
        exp_flush(0, 8'h00);
        wait_done();

        // bits 1,0,1,1,0,0,1,0 -> 8'h4D with write latency check
        b8 = 8'h4D;
        for (int j = 0; j < 8; j++) send_bit(b8[j], 1'b1);
        push(8'h4D);
        chk("latency_pre", {31'b0, w_en}, 0);
        tick();
        chk("latency_wen", {31'b0, w_en}, 1);
        chk("latency_wdata", {24'b0, wdata}, 32'h4D);
        tick();
        chk("single_pulse", {31'b0, w_en}, 0);
        drain();

        for (int i = 0; i < 6; i++) begin
            p = tbl[i].pat;
            for (int j = 0; j < tbl[i].n; j++) begin
                send_bit(p[j], j % 8 != 0);
                if (j % 8 == 7) push(p[j-7 +: 8]);
            end
            if (tbl[i].fl) begin
                b8 = 8'(p >> (tbl[i].n - tbl[i].n % 8)) & 8'((1 << (tbl[i].n % 8)) - 1);
                exp_flush(tbl[i].n % 8, b8);
                wait_done();
            end else drain();
        end

        // bit and flush in the same cycle: final bit included in the word
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        exp_flush(3, 8'h05);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        wait_done();

        // backpressure: word held while full, stalled bit not consumed
        for (int j = 0; j < 7; j++) send_bit(1'b1, 1'b1);
        full = 1'b1;
        send_bit(1'b1, 1'b1);
        push(8'hFF);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        repeat (5) begin
            chk("stall_ready", {31'b0, bit_ready}, 0);
            chk("stall_wen", {31'b0, w_en}, 0);
            tick();
        end
        bit_valid = 1'b0;
        full      = 1'b0;
        send_bit(1'b1, 1'b0);
        exp_flush(1, 8'h01);
        wait_done();

        // reset mid-byte discards the partial word
        for (int j = 0; j < 5; j++) send_bit(1'b1, 1'b1);
        n_rst = 1'b0;
        tick();
        n_rst  = 1'b1;
        bw_exp = 0;
        for (int j = 0; j < 8; j++) send_bit(1'b1, j != 0);
        push(8'hFF);
        drain();
        chk("rst_mid_count", {16'b0, bytes_written}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
